stream_aligner: RTL and testbench

AXI4-Stream aligner sitting between the RX stream input and the skid buffer / DMA write path in the baseband. When enabled, it discards samples until a sync-marked beat arrives, then forwards a packet of exactly maxCnt beats with TLAST on the final beat, so the downstream DMA always receives frame-aligned data. Control and status are exposed through a simple word-addressed register port driven by the block's AXI4-Lite slave shim.

---
 rtl/stream_aligner.sv | 259 +++++++++++++++++++++++++
 tb/tb_stream_aligner.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_aligner.sv
`timescale 1ns/1ps
// stream_aligner
// Drops incoming samples until a sync-marked beat (tuser=1) arrives, then
// forwards a frame of exactly max_cnt beats with tlast on the final beat.
// The output is a single register stage; control/status sit behind a small
// word-addressed register port with combinational read data.
module stream_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tuser,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tlast,
    input  logic                  reg_wr,
    input  logic [4:0]            reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_PASS   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Register read/write path is at least 32 bits wide so a counter of any
    // width can be zero-extended or truncated onto the 32-bit bus.
    localparam int REG_WIDTH = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(1'b0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

    localparam logic [2:0] ADDR_EN      = 3'd0;
    localparam logic [2:0] ADDR_ALIGNED = 3'd1;
    localparam logic [2:0] ADDR_CNT     = 3'd2;
    localparam logic [2:0] ADDR_MAX     = 3'd3;
    localparam logic [2:0] ADDR_PASS    = 3'd4;

    state_t                 state;
    state_t                 state_next;

    logic                   en;
    logic                   cnt_passthrough;
    logic [CNT_WIDTH-1:0]   max_cnt;
    logic [CNT_WIDTH-1:0]   cnt;

    logic                   out_free;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   hit_last;
    logic                   load;
    logic                   aligned;

    logic [2:0]             word_addr;
    logic [REG_WIDTH-1:0]   cnt_wide;
    logic [REG_WIDTH-1:0]   max_wide;
    logic [REG_WIDTH-1:0]   wdata_wide;

    // Packet-position helpers shared by the FSM and the datapath
    always_comb begin
        out_free = !out_tvalid || out_tready;
        cnt_inc  = cnt + CNT_ONE;
        // max_cnt of zero means an unbounded packet: never flag a last beat
        hit_last = (max_cnt != CNT_ZERO) && (cnt_inc == max_cnt);
        aligned  = (state == ST_PASS);
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_next = ST_SEARCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                // Disable only completes once nothing is left in the output stage
                if (!en && out_free) begin
                    state_next = ST_IDLE;
                end else if (load && hit_last && !cnt_passthrough) begin
                    state_next = ST_DONE;
                end else if (load) begin
                    state_next = ST_PASS;
                end else begin
                    state_next = ST_SEARCH;
                end
            end
            ST_PASS: begin
                if (!en && out_free) begin
                    state_next = ST_IDLE;
                end else if (load && hit_last && !cnt_passthrough) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_PASS;
                end
            end
            ST_DONE: begin
                if (!en && out_free) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: input handshake and output-register load strobe
    always_comb begin
        in_tready = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_tready = 1'b0;
                load      = 1'b0;
            end
            ST_SEARCH: begin
                // Non-sync beats are consumed and dropped; only the sync beat loads
                in_tready = en && out_free;
                load      = in_tvalid && in_tready && in_tuser;
            end
            ST_PASS: begin
                in_tready = en && out_free;
                load      = in_tvalid && in_tready;
            end
            ST_DONE: begin
                in_tready = 1'b0;
                load      = 1'b0;
            end
            default: begin
                in_tready = 1'b0;
                load      = 1'b0;
            end
        endcase
    end

    // Beat counter: clears on the way to IDLE, wraps per packet in passthrough
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= CNT_ZERO;
        end else if (state_next == ST_IDLE) begin
            cnt <= CNT_ZERO;
        end else if (load) begin
            if (hit_last && cnt_passthrough) begin
                cnt <= CNT_ZERO;
            end else begin
                cnt <= cnt_inc;
            end
        end else begin
            cnt <= cnt;
        end
    end

    // Output register stage: load on accept, drain on downstream ready, hold when stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            out_tvalid <= 1'b0;
            out_tdata  <= {DATA_WIDTH{1'b0}};
            out_tlast  <= 1'b0;
        end else if (load) begin
            out_tvalid <= 1'b1;
            out_tdata  <= in_tdata;
            out_tlast  <= hit_last;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
            out_tdata  <= out_tdata;
            out_tlast  <= out_tlast;
        end else begin
            out_tvalid <= out_tvalid;
            out_tdata  <= out_tdata;
            out_tlast  <= out_tlast;
        end
    end

    // Address decode and width adaptation between counters and the 32-bit bus
    always_comb begin
        word_addr  = reg_addr[4:2];
        cnt_wide   = REG_WIDTH'(cnt);
        max_wide   = REG_WIDTH'(max_cnt);
        wdata_wide = REG_WIDTH'(reg_wdata);
    end

    // Control registers: written by the register port, unmapped writes ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            en              <= 1'b0;
            cnt_passthrough <= 1'b0;
            max_cnt         <= CNT_ZERO;
        end else if (reg_wr) begin
            case (word_addr)
                ADDR_EN: begin
                    en <= reg_wdata[0];
                end
                ADDR_MAX: begin
                    max_cnt <= CNT_WIDTH'(wdata_wide);
                end
                ADDR_PASS: begin
                    cnt_passthrough <= reg_wdata[0];
                end
                default: begin
                    en              <= en;
                    cnt_passthrough <= cnt_passthrough;
                    max_cnt         <= max_cnt;
                end
            endcase
        end else begin
            en              <= en;
            cnt_passthrough <= cnt_passthrough;
            max_cnt         <= max_cnt;
        end
    end

    // Combinational read mux; unmapped words read as zero
    always_comb begin
        reg_rdata = 32'd0;
        case (word_addr)
            ADDR_EN: begin
                reg_rdata = {31'd0, en};
            end
            ADDR_ALIGNED: begin
                reg_rdata = {31'd0, aligned};
            end
            ADDR_CNT: begin
                reg_rdata = cnt_wide[31:0];
            end
            ADDR_MAX: begin
                reg_rdata = max_wide[31:0];
            end
            ADDR_PASS: begin
                reg_rdata = {31'd0, cnt_passthrough};
            end
            default: begin
                reg_rdata = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_aligner.sv
`timescale 1ns/1ps
// Self-checking bench for stream_aligner: directed scenarios with random
// data/ready, compared against a frame-level reference model.
module tb_stream_aligner;

    logic        clock;
    logic        reset;
    logic        in_tvalid;
    logic        in_tready;
    logic [31:0] in_tdata;
    logic        in_tuser;
    logic        out_tvalid;
    logic        out_tready;
    logic [31:0] out_tdata;
    logic        out_tlast;
    logic        reg_wr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    stream_aligner #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .in_tuser   (in_tuser),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned passed = 0;

    logic [31:0] src_data[$];
    logic        src_user[$];
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];

    logic        in_acc;
    logic        samp_ovalid;
    logic        prev_stall;
    logic [32:0] held;
    logic        mon_aligned;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle, entered and left on a falling edge; samples just before the rising edge.
    task automatic cycle(input int dly);
        #(dly);
        in_acc      = in_tvalid && in_tready;
        samp_ovalid = out_tvalid;
        if (prev_stall) begin
            check("stall_hold", {out_tvalid, out_tlast, out_tdata}, {1'b1, held});
        end
        prev_stall = out_tvalid && !out_tready;
        if (prev_stall) begin
            held = {out_tlast, out_tdata};
            check("stall_in_tready", in_tready, 1'b0);
        end
        if (out_tvalid && out_tready) begin
            got_q.push_back({out_tlast, out_tdata});
            if (mon_aligned) check("aligned_during_pass", reg_rdata, 32'd1);
        end
        @(negedge clock);
    endtask

    task automatic reset_dut();
        reset = 1'b1; in_tvalid = 1'b0; in_tuser = 1'b0; in_tdata = 32'd0;
        out_tready = 1'b1; reg_wr = 1'b0; reg_addr = 5'd0; reg_wdata = 32'd0;
        cycle(4);
        cycle(4);
        reset = 1'b0;
        prev_stall = 1'b0;
        mon_aligned = 1'b0;
    endtask

    task automatic reg_write(input logic [4:0] addr, input logic [31:0] data);
        reg_wr = 1'b1; reg_addr = addr; reg_wdata = data;
        cycle(4);
        reg_wr = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        reg_addr = addr;
        #1;
        check(tag, reg_rdata, exp);
        @(negedge clock);
    endtask

    // Reference: frame starts at the first sync-marked sample; every maxCnt-th beat is last.
    task automatic build_expect(input int unsigned mc, input bit pt);
        int start;
        bit last;
        start = -1;
        exp_q.delete();
        for (int i = 0; i < src_user.size(); i++) begin
            if (start < 0 && src_user[i]) start = i;
        end
        if (start >= 0) begin
            for (int k = 0; start + k < src_data.size(); k++) begin
                last = 1'b0;
                if (mc != 0) last = ((k + 1) % mc) == 0;
                exp_q.push_back({last, src_data[start + k]});
                if (last && !pt) break;
            end
        end
    endtask

    task automatic run_stream(input bit rnd_ready);
        int idx, quiet, cyc;
        idx = 0; quiet = 0; cyc = 0;
        got_q.delete();
        while (quiet < 6 && cyc < 3000) begin
            in_tvalid  = (idx < src_data.size());
            in_tdata   = in_tvalid ? src_data[idx] : 32'd0;
            in_tuser   = in_tvalid ? src_user[idx] : 1'b0;
            out_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle(4);
            if (in_acc) idx++;
            quiet = (in_acc || samp_ovalid) ? 0 : quiet + 1;
            cyc++;
        end
        check("stream_timeout", cyc < 3000, 1'b1);
        in_tvalid = 1'b0; in_tuser = 1'b0; out_tready = 1'b1;
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check($sformatf("%s_len", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic setup(input int unsigned mc, input bit pt);
        reg_write(5'h0C, mc);
        reg_write(5'h10, {31'd0, pt});
        reg_write(5'h00, 32'd1);
    endtask

    task automatic fill_ramp(input int first, input int n, input int sync_val);
        src_data.delete(); src_user.delete();
        for (int i = first; i < first + n; i++) begin
            src_data.push_back(i);
            src_user.push_back(i == sync_val);
        end
    endtask

    initial begin
        int acc, cyc;
        int unsigned mc;
        bit pt;
        prev_stall = 1'b0; mon_aligned = 1'b0; held = 33'd0;
        reset_dut();

        // Reset state
        check("rst_out_tvalid", out_tvalid, 1'b0);
        check("rst_out_tdata", out_tdata, 32'd0);
        check("rst_out_tlast", out_tlast, 1'b0);
        check("rst_in_tready", in_tready, 1'b0);
        for (int a = 0; a < 8; a++) check_reg($sformatf("rst_reg%0d", a), 5'(a * 4), 32'd0);
        reg_write(5'h14, 32'hFFFF_FFFF);
        check_reg("unmapped_read", 5'h14, 32'd0);
        check_reg("unmapped_no_en", 5'h00, 32'd0);

        // Basic alignment (maxCnt written through an address with low bits set)
        reg_write(5'h0E, 32'h20);
        check_reg("maxcnt_rb", 5'h0C, 32'h20);
        setup(32'h20, 1'b0);
        fill_ramp(0, 64, 5);
        build_expect(32'h20, 1'b0);
        run_stream(1'b0);
        compare_stream("basic");
        check("basic_done_tready", in_tready, 1'b0);
        check_reg("basic_cnt", 5'h08, 32'h20);
        check_reg("basic_aligned", 5'h04, 32'd0);

        // Backpressure
        reset_dut();
        setup(32'h20, 1'b0);
        run_stream(1'b1);
        compare_stream("bp");

        // Passthrough
        reset_dut();
        setup(32'd4, 1'b1);
        fill_ramp(0, 16, 0);
        build_expect(4, 1'b1);
        reg_addr = 5'h04;
        mon_aligned = 1'b1;
        run_stream(1'b1);
        mon_aligned = 1'b0;
        compare_stream("pt");
        check_reg("pt_aligned_after", 5'h04, 32'd1);

        // Disable after 3 beats, then re-enable and re-search
        reset_dut();
        setup(32'd10, 1'b0);
        acc = 0; cyc = 0;
        got_q.delete();
        while (acc < 3 && cyc < 100) begin
            in_tvalid = 1'b1; in_tdata = acc; in_tuser = (acc == 0); out_tready = 1'b1;
            #1;
            if (in_tready && acc == 2) begin
                reg_wr = 1'b1; reg_addr = 5'h00; reg_wdata = 32'd0;
            end
            cycle(3);
            reg_wr = 1'b0;
            if (in_acc) acc++;
            cyc++;
        end
        check("dis_timeout", cyc < 100, 1'b1);
        in_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) cycle(4);
        fill_ramp(0, 3, 0);
        build_expect(10, 1'b0);
        compare_stream("dis");
        check("dis_tready", in_tready, 1'b0);
        check_reg("dis_cnt", 5'h08, 32'd0);
        check_reg("dis_aligned", 5'h04, 32'd0);
        reg_write(5'h00, 32'd1);
        fill_ramp(95, 25, 100);
        src_user[9] = 1'b1;
        build_expect(10, 1'b0);
        run_stream(1'b1);
        compare_stream("reen");

        // maxCnt = 1: sync beat alone carries tlast
        reset_dut();
        setup(32'd1, 1'b0);
        src_data.delete(); src_user.delete();
        for (int i = 0; i < 20; i++) begin
            src_data.push_back($urandom);
            src_user.push_back(i == 7 ? 1'b1 : (i > 7 ? 1'($urandom_range(0, 1)) : 1'b0));
        end
        build_expect(1, 1'b0);
        run_stream(1'b1);
        compare_stream("mc1");
        check_reg("mc1_cnt", 5'h08, 32'd1);

        // maxCnt = 0: unbounded, no tlast
        reset_dut();
        setup(32'd0, 1'b0);
        src_data.delete(); src_user.delete();
        for (int i = 0; i < 70; i++) begin
            src_data.push_back($urandom);
            src_user.push_back(i == 6 ? 1'b1 : (i > 6 ? 1'($urandom_range(0, 1)) : 1'b0));
        end
        build_expect(0, 1'b0);
        run_stream(1'b1);
        compare_stream("mc0");
        check_reg("mc0_cnt", 5'h08, 32'd64);

        // Randomized frames
        for (int r = 0; r < 3; r++) begin
            reset_dut();
            mc = $urandom_range(1, 8);
            pt = 1'($urandom_range(0, 1));
            setup(mc, pt);
            src_data.delete(); src_user.delete();
            for (int i = 0; i < 40; i++) begin
                src_data.push_back($urandom);
                src_user.push_back($urandom_range(0, 7) == 0);
            end
            build_expect(mc, pt);
            run_stream(1'b1);
            compare_stream($sformatf("rnd%0d", r));
        end

        // Reset in the middle of PASS with a pending output beat
        reset_dut();
        setup(32'd0, 1'b0);
        fill_ramp(0, 10, 0);
        build_expect(0, 1'b0);
        run_stream(1'b0);
        compare_stream("pre_rst");
        in_tvalid = 1'b1; in_tdata = 32'h55; in_tuser = 1'b0; out_tready = 1'b0;
        cycle(4);
        in_tvalid = 1'b0;
        check("pre_rst_pending", out_tvalid, 1'b1);
        reset = 1'b1;
        cycle(4);
        reset = 1'b0;
        prev_stall = 1'b0;
        out_tready = 1'b1;
        check("mid_rst_tvalid", out_tvalid, 1'b0);
        check("mid_rst_tdata", out_tdata, 32'd0);
        check("mid_rst_tlast", out_tlast, 1'b0);
        check("mid_rst_tready", in_tready, 1'b0);
        for (int a = 0; a < 8; a++) check_reg($sformatf("mid_rst_reg%0d", a), 5'(a * 4), 32'd0);
        reg_write(5'h00, 32'd1);
        check("idle_after_rst", in_tready, 1'b0);
        cycle(4);
        check("search_after_idle", in_tready, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
